md_unit_param: RTL
==================

Name: md_unit_param

Overview:
- Parametrised iterative multiply/divide unit; next generation of the 32-bit vscale_mul_div.
- Sits beside the integer ALU in the execute stage and serves the RV32M/RV64M operations MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Generalised in data width and bits retired per cycle.
- New over the previous block: response backpressure, a request tag carried through, a kill input, and full RISC-V divide-by-zero/overflow results.

Parameters:
- W, 32: operand/result width; must be 32 or 64.
- MUL_BPC, 4: multiplier bits retired per cycle; 2, 4 or 8; must divide W.
- DIV_BPC, 1: quotient bits retired per cycle; 1 or 2.
- TAG_W, 5: width of the request tag.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle; can accept
- req_op  in  1  `MD_OP_MUL or `MD_OP_DIV (vscale_md_constants.vh)
- req_out_sel  in  1  `MD_OUT_LO = low product / quotient; `MD_OUT_HI = high product / remainder
- req_in_1_signed  in  1  operand 1 signed
- req_in_2_signed  in  1  operand 2 signed
- req_in_1  in  W  multiplicand / dividend
- req_in_2  in  W  multiplier / divisor
- req_tag  in  TAG_W  opaque tag
- kill  in  1  abort the in-flight operation
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_result  out  W  result
- resp_tag  out  TAG_W  tag of the result

Behaviour:
- State machine states: IDLE, MUL, DIV, FIX, DONE.
- Reset:
  - State goes to IDLE.
  - req_ready=1, resp_valid=0.
  - resp_result and resp_tag are 0.
  - Reset wins over every other event, including mid-operation.
- Accept:
  - A request is accepted on a clock edge where req_valid & req_ready.
  - Operands, flags, out_sel and tag are latched at that edge.
  - req_ready = (state==IDLE). No request is accepted in the same cycle a response is consumed.
- MUL:
  - Radix-2^MUL_BPC Booth/shift-add over the sign- or zero-extended operands.
  - The iteration counter loads W/MUL_BPC and decrements each cycle.
  - At 0 the state moves to DONE. resp_valid is first high W/MUL_BPC+1 cycles after the accept edge (W=32, MUL_BPC=4: 9).
  - The full 2W-bit product is formed; out_sel selects [W-1:0] or [2W-1:W].
- DIV:
  - Restoring division on operand magnitudes, DIV_BPC bits per cycle, over W/DIV_BPC cycles.
  - Then one FIX cycle applies signs: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - resp_valid is first high W/DIV_BPC+2 cycles after the accept edge (W=32, DIV_BPC=1: 34).
  - Divisor==0: go directly to DONE (latency 2). Quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): go directly to DONE (latency 2). Quotient = dividend; remainder = 0.
  - The signed flag used for each operand is its own req_in_N_signed.
- DONE:
  - resp_valid=1. resp_result and resp_tag are held stable until resp_valid & resp_ready; then return to IDLE.
  - If resp_ready is high in the first DONE cycle, the unit is IDLE (req_ready=1) on the next cycle.
- Kill:
  - In MUL, DIV or FIX, kill=1 returns the unit to IDLE next cycle with no response.
  - In DONE, kill also drops the pending response.
  - kill in IDLE has no effect and does not block an accept in the same cycle.
- resp_valid never asserts for a killed operation; exactly one response per accepted, unkilled request.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined:
  - In MUL, after each iteration, when the remaining unconsumed multiplier bits all equal the multiplier's sign-extension bit (all 0 for unsigned), the counter is forced to 0 and DONE is entered on the next cycle.
  - Minimum MUL latency is 2. Results are identical to those without the macro.
- Undefined: MUL latency is always W/MUL_BPC+1; no early-out logic is built. DIV is unaffected either way.

Test Plan (W=32, MUL_BPC=4, DIV_BPC=1, macro off unless stated):
- MUL signed×signed, 7 × 0xFFFFFFFD, LO, tag 3 -> resp_result 0xFFFFFFEB, resp_tag 3, resp_valid 9 cycles after accept; HI of same -> 0xFFFFFFFF.
- MUL unsigned, 0xFFFFFFFF × 0xFFFFFFFF, HI -> 0xFFFFFFFE; LO -> 0x00000001. Signed×unsigned, 0xFFFFFFFF × 2, HI -> 0xFFFFFFFF.
- DIV signed, 0xFFFFFFF9 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, latency 34. Unsigned, 100 / 7 -> 14, remainder 2.
- DIV 100 / 0 -> quotient 0xFFFFFFFF, remainder 100, latency 2. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Backpressure and kill:
  - Hold resp_ready=0 for 5 cycles after resp_valid -> result/tag stable, req_ready=0; release -> req_ready=1 next cycle.
  - kill at cycle 4 of a MUL -> no resp_valid, req_ready=1 next cycle; the next request completes normally.
- MD_EARLY_OUT_EN defined: MUL signed 5 × 3 LO -> 15 with latency ≤ 3; random signed/unsigned sweep matches the macro-off results.

Source files
------------

// File: rtl/md_unit_param_if.sv
// -----------------------------------------------------------------------------
// md_unit_param_if
// Request/response bundle between the execute stage and md_unit_param.
//
// Parameters:
//    W      operand/result width
//    TAG_W  request tag width
//
// Signals:
//    req_valid / req_ready        request handshake (ready = unit idle)
//    req_op                       0 = multiply, 1 = divide
//    req_out_sel                  0 = low product / quotient, 1 = high product / remainder
//    req_in_1_signed/_2_signed    per-operand signedness
//    req_in_1 / req_in_2          multiplicand-dividend / multiplier-divisor
//    req_tag                      opaque tag returned with the result
//    kill                         abort the in-flight operation
//    resp_valid / resp_ready      response handshake
//    resp_result / resp_tag       result and its tag
//
// Modports: master = requester (execute stage), slave = the unit.
// -----------------------------------------------------------------------------
interface md_unit_param_if #(
   parameter int W     = 32,
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic             req_op;
   logic             req_out_sel;
   logic             req_in_1_signed;
   logic             req_in_2_signed;
   logic [W-1:0]     req_in_1;
   logic [W-1:0]     req_in_2;
   logic [TAG_W-1:0] req_tag;
   logic             kill;
   logic             resp_valid;
   logic             resp_ready;
   logic [W-1:0]     resp_result;
   logic [TAG_W-1:0] resp_tag;

   modport master (
      output req_valid, req_op, req_out_sel, req_in_1_signed, req_in_2_signed,
             req_in_1, req_in_2, req_tag, kill, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_tag
   );

   modport slave (
      input  req_valid, req_op, req_out_sel, req_in_1_signed, req_in_2_signed,
             req_in_1, req_in_2, req_tag, kill, resp_ready,
      output req_ready, resp_valid, resp_result, resp_tag
   );
endinterface

// File: rtl/md_unit_param.sv
// -----------------------------------------------------------------------------
// md_unit_param
// Iterative RV32M/RV64M multiply/divide unit with response backpressure,
// tag pass-through and kill.
//
// Parameters:
//    W        operand/result width (32 or 64)
//    MUL_BPC  multiplier bits retired per cycle (2, 4 or 8; divides W)
//    DIV_BPC  quotient bits retired per cycle (1 or 2)
//    TAG_W    request tag width
//
// Ports:
//    clk      clock
//    reset    synchronous active-high reset
//    bus      md_unit_param_if.slave (request/response handshake, kill)
//
// Optional build macro: MD_EARLY_OUT_EN - multiply terminates as soon as the
// unconsumed multiplier bits are pure sign extension. Results are unchanged.
//
// Latency (accept edge to first resp_valid): MUL W/MUL_BPC+1, DIV W/DIV_BPC+2,
// divide-by-zero and signed overflow 2.
// -----------------------------------------------------------------------------
module md_unit_param #(
   parameter int W       = 32,
   parameter int MUL_BPC = 4,
   parameter int DIV_BPC = 1,
   parameter int TAG_W   = 5
) (
   input  logic           clk,
   input  logic           reset,
   md_unit_param_if.slave bus
);

   localparam logic MD_OP_MUL  = 1'b0;
   localparam logic MD_OUT_HI  = 1'b1;
   localparam int   MUL_ITERS  = W / MUL_BPC;
   localparam int   DIV_ITERS  = W / DIV_BPC;
   localparam int   CNT_W      = $clog2(W + 1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               out_sel_q;
   logic [TAG_W-1:0]   tag_q;

   // multiply datapath
   logic [2*W-1:0]     mcand_q;
   logic [W-1:0]       mplier_q;
   logic               msign_q;
   logic [2*W-1:0]     acc_q;

   // divide datapath
   logic [W-1:0]       rem_q;
   logic [W-1:0]       quo_q;
   logic [W-1:0]       dvs_q;
   logic [W-1:0]       dvd_q;
   logic               q_neg_q;
   logic               r_neg_q;
   logic               special_q;
   logic               divz_q;

   // registered outputs
   logic               req_ready_q;
   logic               resp_valid_q;
   logic [W-1:0]       resp_result_q;
   logic [TAG_W-1:0]   resp_tag_q;

   assign bus.req_ready   = req_ready_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = resp_result_q;
   assign bus.resp_tag    = resp_tag_q;

   // ---------------------------------------------------------------- request
   logic               in_a_neg, in_b_neg;
   logic [W-1:0]       in_a_mag, in_b_mag;
   logic               in_divz, in_ovf, accept;

   always_comb begin
      in_a_neg = bus.req_in_1_signed & bus.req_in_1[W-1];
      in_b_neg = bus.req_in_2_signed & bus.req_in_2[W-1];
      in_a_mag = in_a_neg ? -bus.req_in_1 : bus.req_in_1;
      in_b_mag = in_b_neg ? -bus.req_in_2 : bus.req_in_2;
      in_divz  = (bus.req_in_2 == '0);
      in_ovf   = bus.req_in_1_signed & bus.req_in_2_signed &
                 (bus.req_in_1 == {1'b1, {(W-1){1'b0}}}) & (bus.req_in_2 == '1);
      accept   = bus.req_valid & req_ready_q;
   end

   // ---------------------------------------------------------------- multiply
   // Each step adds mcand * (next MUL_BPC-bit multiplier digit). Digits are
   // unsigned except the top one, which carries negative weight for a signed
   // multiplier, so the 2W-bit sum is the exact product.
   logic [MUL_BPC-1:0] mul_digit;
   logic               mul_last, mul_early;
   logic [2*W-1:0]     mul_partial, mcand_d, acc_d;
   logic [W-1:0]       mplier_d;

   always_comb begin
      mul_digit   = mplier_q[MUL_BPC-1:0];
      mul_last    = (cnt_q == CNT_W'(1));
      mul_partial = mcand_q * {{(2*W-MUL_BPC){1'b0}}, mul_digit};
      if (mul_last && msign_q && mul_digit[MUL_BPC-1])
         mul_partial = mul_partial - (mcand_q << MUL_BPC);
      mcand_d  = mcand_q << MUL_BPC;
      mplier_d = {{MUL_BPC{msign_q}}, mplier_q[W-1:MUL_BPC]};
      acc_d    = acc_q + mul_partial;
      mul_early = 1'b0;
`ifdef MD_EARLY_OUT_EN
      // Remaining digits all sign bits: they contribute 0 (unsigned/positive)
      // or exactly -mcand at the current weight (negative), so finish now.
      if (!mul_last && (mplier_d == {W{msign_q}})) begin
         mul_early = 1'b1;
         if (msign_q)
            acc_d = acc_d - mcand_d;
      end
`endif
   end

   // ---------------------------------------------------------------- divide
   // Restoring steps chained DIV_BPC deep; the dividend shifts out of the top
   // of quo while quotient bits shift in at the bottom.
   logic [W-1:0] dv_rem [0:DIV_BPC];
   logic [W-1:0] dv_quo [0:DIV_BPC];

   assign dv_rem[0] = rem_q;
   assign dv_quo[0] = quo_q;

   generate
      for (genvar gi = 0; gi < DIV_BPC; gi++) begin : g_div_step
         logic [W:0] sh;
         logic [W:0] diff;
         assign sh   = {dv_rem[gi], dv_quo[gi][W-1]};
         assign diff = sh - {1'b0, dvs_q};
         // diff[W] set means the trial subtraction borrowed: restore.
         assign dv_rem[gi+1] = diff[W] ? sh[W-1:0] : diff[W-1:0];
         assign dv_quo[gi+1] = {dv_quo[gi][W-2:0], ~diff[W]};
      end
   endgenerate

   logic [W-1:0] fix_quo, fix_rem, special_res;

   always_comb begin
      fix_quo = q_neg_q ? -quo_q : quo_q;
      fix_rem = r_neg_q ? -rem_q : rem_q;
      if (divz_q)
         special_res = (out_sel_q == MD_OUT_HI) ? dvd_q : '1;
      else
         special_res = (out_sel_q == MD_OUT_HI) ? '0 : dvd_q;
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         out_sel_q     <= 1'b0;
         tag_q         <= '0;
         mcand_q       <= '0;
         mplier_q      <= '0;
         msign_q       <= 1'b0;
         acc_q         <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         dvs_q         <= '0;
         dvd_q         <= '0;
         q_neg_q       <= 1'b0;
         r_neg_q       <= 1'b0;
         special_q     <= 1'b0;
         divz_q        <= 1'b0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_tag_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  out_sel_q   <= bus.req_out_sel;
                  tag_q       <= bus.req_tag;
                  req_ready_q <= 1'b0;
                  if (bus.req_op == MD_OP_MUL) begin
                     state_q  <= S_MUL;
                     cnt_q    <= CNT_W'(MUL_ITERS);
                     mcand_q  <= {{W{in_a_neg}}, bus.req_in_1};
                     mplier_q <= bus.req_in_2;
                     msign_q  <= in_b_neg;
                     acc_q    <= '0;
                  end else begin
                     state_q   <= S_DIV;
                     // Special cases burn one dummy step so they still
                     // answer two cycles after accept.
                     cnt_q     <= (in_divz | in_ovf) ? CNT_W'(1) : CNT_W'(DIV_ITERS);
                     rem_q     <= '0;
                     quo_q     <= in_a_mag;
                     dvs_q     <= in_b_mag;
                     dvd_q     <= bus.req_in_1;
                     q_neg_q   <= in_a_neg ^ in_b_neg;
                     r_neg_q   <= in_a_neg;
                     special_q <= in_divz | in_ovf;
                     divz_q    <= in_divz;
                  end
               end
            end

            S_MUL: begin
               if (bus.kill) begin
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
               end else if (cnt_q == '0) begin
                  state_q       <= S_DONE;
                  resp_valid_q  <= 1'b1;
                  resp_tag_q    <= tag_q;
                  resp_result_q <= (out_sel_q == MD_OUT_HI) ? acc_q[2*W-1:W] : acc_q[W-1:0];
               end else begin
                  acc_q    <= acc_d;
                  mcand_q  <= mcand_d;
                  mplier_q <= mplier_d;
                  cnt_q    <= mul_early ? '0 : cnt_q - CNT_W'(1);
               end
            end

            S_DIV: begin
               if (bus.kill) begin
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
               end else if (cnt_q == '0) begin
                  if (special_q) begin
                     state_q       <= S_DONE;
                     resp_valid_q  <= 1'b1;
                     resp_tag_q    <= tag_q;
                     resp_result_q <= special_res;
                  end else begin
                     state_q <= S_FIX;
                  end
               end else begin
                  rem_q <= dv_rem[DIV_BPC];
                  quo_q <= dv_quo[DIV_BPC];
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end

            S_FIX: begin
               if (bus.kill) begin
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
               end else begin
                  state_q       <= S_DONE;
                  resp_valid_q  <= 1'b1;
                  resp_tag_q    <= tag_q;
                  resp_result_q <= (out_sel_q == MD_OUT_HI) ? fix_rem : fix_quo;
               end
            end

            S_DONE: begin
               // Result and tag stay put until consumed or killed.
               if (bus.kill || bus.resp_ready) begin
                  state_q      <= S_IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end

            default: begin
               state_q      <= S_IDLE;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule
